// File: rtl/delay_var.sv
// Variable-length multi-channel sample delay line built on a circular buffer.
// Delay counts input strobes; outputs are zero-filled until the buffer holds D_act samples.
module delay_var #(
    parameter  int unsigned W    = 16,
    parameter  int unsigned CH   = 2,
    parameter  int unsigned DMAX = 1024,
    localparam int unsigned AW   = $clog2(DMAX)
) (
    input  logic          clk,
    input  logic          reset_b,
    input  logic [CH*W-1:0] din,
    input  logic          din_vld,
    input  logic [AW:0]   delay,
    input  logic          delay_ld,
    output logic [CH*W-1:0] dout,
    output logic          dout_vld,
    output logic          primed
);

    localparam int unsigned DW    = CH * W;
    localparam logic [AW:0] DMaxW = DMAX[AW:0];

    logic [DW-1:0] mem [DMAX];

    logic [AW-1:0] wp_q, wp_d, rd_addr;
    logic [AW:0]   d_act_q, d_act_d, d_ld, d_eff;
    logic [AW:0]   fc_q, fc_d, fc_eff;
    logic [DW-1:0] rd_q;
    logic          s1_vld_q, s1_real_q;
    logic [DW-1:0] dout_q;
    logic          dout_vld_q, primed_q;

    always_comb begin
        d_ld = delay;
        if (delay == '0) begin
            d_ld = (AW+1)'(1);
        end else if (delay > DMaxW) begin
            d_ld = DMaxW;
        end

        // A load in the same cycle as a strobe applies to that strobe as n=0.
        d_eff  = delay_ld ? d_ld : d_act_q;
        fc_eff = delay_ld ? '0 : fc_q;

        // With d_eff == DMAX the low bits are zero: the read hits the word being overwritten.
        rd_addr = wp_q - d_eff[AW-1:0];

        wp_d    = wp_q;
        fc_d    = fc_eff;
        d_act_d = d_eff;
        if (din_vld) begin
            wp_d = wp_q + AW'(1);
            if (fc_eff != d_eff) begin
                fc_d = fc_eff + (AW+1)'(1);
            end
        end
    end

    // Buffer has no reset; the NBA read returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (din_vld) begin
            rd_q        <= mem[rd_addr];
            mem[wp_q]   <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            wp_q       <= '0;
            fc_q       <= '0;
            d_act_q    <= (AW+1)'(1);
            s1_vld_q   <= 1'b0;
            s1_real_q  <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            primed_q   <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            fc_q       <= fc_d;
            d_act_q    <= d_act_d;
            s1_vld_q   <= din_vld;
            dout_vld_q <= s1_vld_q;
            if (din_vld) begin
                s1_real_q <= (fc_eff == d_eff);
            end
            if (s1_vld_q) begin
                dout_q   <= s1_real_q ? rd_q : '0;
                primed_q <= s1_real_q;
            end
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign primed   = primed_q;

endmodule

// File: tb/tb_delay_var.sv
// Scoreboard bench for delay_var: stimulus pushes expected outputs, a negedge monitor pops them.
module tb_delay_var;

    localparam int unsigned W    = 16;
    localparam int unsigned CH   = 2;
    localparam int unsigned DMAX = 1024;
    localparam int unsigned AW   = $clog2(DMAX);

    logic            clk;
    logic            reset_b;
    logic [CH*W-1:0] din;
    logic            din_vld;
    logic [AW:0]     delay;
    logic            delay_ld;
    logic [CH*W-1:0] dout;
    logic            dout_vld;
    logic            primed;

    delay_var #(.W(W), .CH(CH), .DMAX(DMAX)) dut (
        .clk      (clk),
        .reset_b  (reset_b),
        .din      (din),
        .din_vld  (din_vld),
        .delay    (delay),
        .delay_ld (delay_ld),
        .dout     (dout),
        .dout_vld (dout_vld),
        .primed   (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        primed;
        int          edge_no;
    } exp_t;

    exp_t        q[$];
    logic [15:0] hist[$];
    int          n_m;
    int          d_m;
    logic [31:0] last_m;
    bit          mon_en = 1'b0;
    int          total  = 0;
    int          passed = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [31:0] mk(input logic [15:0] k);
        return {k + 16'h4000, k};
    endfunction

    function automatic int clampd(input int v);
        if (v == 0) return 1;
        if (v > int'(DMAX)) return int'(DMAX);
        return v;
    endfunction

    // One stimulus cycle; the reference model tracks the strobe index since the last load/reset.
    task automatic drive(input bit vld, input bit ld, input int dl, input logic [15:0] k);
        exp_t e;
        din      = mk(k);
        din_vld  = vld;
        delay_ld = ld;
        delay    = dl[AW:0];
        if (ld) begin
            d_m = clampd(dl);
            n_m = 0;
        end
        if (vld) begin
            e.primed  = (n_m >= d_m);
            e.data    = e.primed ? mk(hist[hist.size() - d_m]) : 32'h0;
            e.edge_no = cyc + 2;
            q.push_back(e);
            hist.push_back(k);
            n_m++;
        end
        @(posedge clk);
        #1;
        din_vld  = 1'b0;
        delay_ld = 1'b0;
    endtask

    task automatic do_reset();
        reset_b  = 1'b0;
        din_vld  = 1'b0;
        delay_ld = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        last_m = 32'h0;
        n_m    = 0;
        d_m    = 1;
        check("reset_dout", dout, 0);
        check("reset_dout_vld", dout_vld, 0);
        check("reset_primed", primed, 0);
        reset_b = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (dout_vld) begin
                if (q.size() == 0) begin
                    check("spurious_dout_vld", dout_vld, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("dout", dout, e.data);
                    check("primed", primed, e.primed);
                    check("latency", cyc, e.edge_no);
                    last_m = e.data;
                end
            end else begin
                check("hold", dout, last_m);
            end
        end
    end

    initial begin
        reset_b  = 1'b0;
        din      = '0;
        din_vld  = 1'b0;
        delay    = '0;
        delay_ld = 1'b0;
        n_m      = 0;
        d_m      = 1;
        last_m   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        mon_en = 1'b1;

        // delay 4, continuous ramp: four zero outputs, then 1 primed
        drive(0, 1, 4, 0);
        for (int k = 1; k <= 12; k++) drive(1, 0, 0, 16'(k));
        repeat (4) drive(0, 0, 0, 0);

        // delay 3, strobe every 3rd cycle; monitor checks hold between strobes
        drive(0, 1, 3, 0);
        for (int k = 1; k <= 8; k++) begin
            drive(1, 0, 0, 16'(100 + k));
            drive(0, 0, 0, 0);
            drive(0, 0, 0, 0);
        end

        // primed at delay 8, then reload to 2 together with a strobe
        drive(0, 1, 8, 0);
        for (int k = 1; k <= 12; k++) drive(1, 0, 0, 16'(200 + k));
        drive(1, 1, 2, 16'd300);
        for (int k = 1; k <= 6; k++) drive(1, 0, 0, 16'(300 + k));
        repeat (3) drive(0, 0, 0, 0);

        // delay 0 clamps to 1
        drive(0, 1, 0, 0);
        for (int k = 1; k <= 5; k++) drive(1, 0, 0, 16'(400 + k));
        repeat (3) drive(0, 0, 0, 0);

        // delay DMAX+5 clamps to DMAX; 2*DMAX samples exercise the pointer wrap
        drive(0, 1, int'(DMAX) + 5, 0);
        for (int k = 0; k < 2 * int'(DMAX); k++) drive(1, 0, 0, 16'(k));
        repeat (3) drive(0, 0, 0, 0);

        // mid-stream reset, then restart with delay 1
        drive(0, 1, 2, 0);
        for (int k = 1; k <= 6; k++) drive(1, 0, 0, 16'(500 + k));
        do_reset();
        drive(1, 1, 1, 16'd600);
        for (int k = 1; k <= 4; k++) drive(1, 0, 0, 16'(600 + k));

        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/delay_var.md
DELAY_VAR -- requirements
Module: delay_var

Interface
REQ-001 SHALL have parameter W, default 16, sample width per channel in bits.
REQ-002 SHALL have parameter CH, default 2, number of channels delayed in lockstep.
REQ-003 SHALL have parameter DMAX, default 1024, maximum delay in samples (power of 2, 2..65536).
REQ-004 SHALL have derived localparam AW = clog2(DMAX); delay port width AW+1.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port reset_b  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port din  input  CH*W  packed channel samples, channel k at bits [k*W +: W].
REQ-008 SHALL have port din_vld  input  1  sample strobe; delay is counted in strobes, not clocks.
REQ-009 SHALL have port delay  input  AW+1  requested delay in samples.
REQ-010 SHALL have port delay_ld  input  1  one-cycle pulse loading delay.
REQ-011 SHALL have port dout  output  CH*W  delayed samples, same packing as din.
REQ-012 SHALL have port dout_vld  output  1  output strobe.
REQ-013 SHALL have port primed  output  1  high when dout carries real delayed data.

Function
REQ-014 SHALL store samples in a circular buffer of DMAX words of CH*W bits (inferable block RAM, read-before-write), write pointer wp of AW bits.
REQ-015 On din_vld SHALL write din at wp and increment wp modulo DMAX (wrap DMAX-1 -> 0).
REQ-016 On din_vld SHALL read address (wp - D_act) mod DMAX in the same cycle, before that cycle's write.
REQ-017 D_act SHALL be the active delay register: delay_ld loads clamp(delay, 1, DMAX) (0 -> 1, >DMAX -> DMAX).
REQ-018 Fixed latency: din_vld at cycle t SHALL give dout_vld at t+2; no backpressure; every din_vld produces exactly one dout_vld.
REQ-019 Output for the n-th strobe (n counted from 0 since last reset/load) SHALL be the sample of strobe n-D_act if n >= D_act, else all zeros.
REQ-020 Fill counter fc (AW+1 bits) SHALL increment on each din_vld, saturating at D_act; primed = (fc == D_act), registered and aligned with dout.
REQ-021 delay_ld SHALL reset fc to 0 and deassert primed from the next output; wp and buffer contents SHALL NOT be cleared.
REQ-022 delay_ld and din_vld in the same cycle: the new D_act SHALL apply to that sample, which is n=0 of the new fill.
REQ-023 Samples already in the 2-stage pipeline when delay_ld occurs SHALL complete with their original data and primed value.
REQ-024 dout SHALL hold its last value between strobes; dout_vld SHALL be a one-cycle pulse per sample.
REQ-025 D_act = DMAX SHALL read the location being overwritten that cycle (old data), giving exactly DMAX samples delay.
REQ-026 Back-to-back din_vld every cycle SHALL be sustained at full rate.

Reset
REQ-027 When reset_b is low at a rising edge: wp=0, fc=0, D_act=clamp(DMAX/2... no: D_act=1, dout=0, dout_vld=0, primed=0, pipeline strobes cleared.
REQ-028 Buffer RAM contents SHALL NOT be reset; zero-fill via REQ-019 guarantees no stale data at dout.
REQ-029 Reset asserted mid-stream SHALL discard in-flight samples; no dout_vld in the cycle after the reset edge.

Verification
REQ-030 Reset, load delay=4, din_vld every cycle with ramp 1,2,3,... on both channels -> first 4 outputs 0 with primed=0, 5th output 1 with primed=1, each dout_vld 2 cycles after its din_vld.
REQ-031 delay=3, din_vld every 3rd cycle, ramp data -> outputs 0,0,0,1,2,...; dout_vld spaced 3 cycles; dout stable between strobes.
REQ-032 delay=DMAX, 2*DMAX continuous samples -> first DMAX outputs 0, output DMAX equals sample 0, wp wraps without glitch.
REQ-033 Primed at delay=8, pulse delay_ld with delay=2 simultaneous with a din_vld -> 2 in-flight outputs unchanged, then 2 zero outputs (primed=0), then sample from 2 strobes earlier (primed=1).
REQ-034 Load delay=0 and delay=DMAX+5 -> behaves as 1 and DMAX respectively.
REQ-035 Stream running, drop reset_b for 1 cycle -> dout=0, dout_vld=0, primed=0 after the edge; restart with delay=1 gives one zero output then data.
